// File: rtl/rot_detect_pkg.sv
// Shared types and constants for the rotation-amount detector.
package rot_detect_pkg;

    localparam int ROT_N  = 16;
    localparam int ROT_AW = $clog2(ROT_N);

    localparam logic ROT_LEFT  = 1'b1;
    localparam logic ROT_RIGHT = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } rot_state_t;

endpackage

// File: rtl/rotate_operation.sv
// Combinational N-bit rotate; left when direction == ROT_LEFT, amount 0 is identity.
module rotate_operation
    import rot_detect_pkg::*;
#(
    parameter int N  = ROT_N,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  data_in,
    input  logic [AW-1:0] amount,
    input  logic          direction,
    output logic [N-1:0]  data_out
);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] shifted_l;
    logic [2*N-1:0] shifted_r;

    // Shifting a doubled copy yields the wrapped bits without an N-k shift term.
    always_comb begin
        doubled   = {data_in, data_in};
        shifted_l = doubled << amount;
        shifted_r = doubled >> amount;
        if (direction == ROT_LEFT)
            data_out = shifted_l[2*N-1:N];
        else
            data_out = shifted_r[N-1:0];
    end

endmodule

// File: rtl/rotate_detect.sv
// Sequential search for the smallest rotation mapping data_ref onto data_rot.
// Optional macro ROT_DETECT_MASK_EN: full scan with a per-amount match_mask output.
module rotate_detect
    import rot_detect_pkg::*;
#(
    parameter int N  = ROT_N,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  data_ref,
    input  logic [N-1:0]  data_rot,
    input  logic          rotate_operation,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW-1:0] rot_amt
`ifdef ROT_DETECT_MASK_EN
    ,
    output logic [N-1:0]  match_mask
`endif
);

    localparam logic [AW-1:0] CAND_LAST = AW'(N - 1);

    rot_state_t    state_q, state_d;
    logic [N-1:0]  ref_q;
    logic [N-1:0]  rot_q;
    logic          dir_q;
    logic [AW-1:0] cand;
    logic [N-1:0]  cand_word;
    logic          hit;

    rotate_operation #(.N(N), .AW(AW)) u_rotate (
        .data_in  (ref_q),
        .amount   (cand),
        .direction(dir_q),
        .data_out (cand_word)
    );

    assign hit = (cand_word == rot_q);

`ifdef ROT_DETECT_MASK_EN
    logic [N-1:0] mask_next;

    function automatic logic [AW-1:0] lowest_set(input logic [N-1:0] m);
        logic [AW-1:0] r;
        r = '0;
        for (int unsigned i = N; i > 0; i--) begin
            if (m[i-1])
                r = AW'(i - 1);
        end
        return r;
    endfunction

    always_comb begin
        mask_next       = match_mask;
        mask_next[cand] = match_mask[cand] | hit;
    end
`endif

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start)
                    state_d = SEARCH;
            end
            SEARCH: begin
                busy = 1'b1;
`ifdef ROT_DETECT_MASK_EN
                if (cand == CAND_LAST)
                    state_d = DONE;
`else
                if (hit || cand == CAND_LAST)
                    state_d = DONE;
`endif
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ref_q      <= '0;
            rot_q      <= '0;
            dir_q      <= ROT_RIGHT;
            cand       <= '0;
            found      <= 1'b0;
            rot_amt    <= '0;
`ifdef ROT_DETECT_MASK_EN
            match_mask <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ref_q      <= data_ref;
                        rot_q      <= data_rot;
                        dir_q      <= rotate_operation;
                        cand       <= '0;
                        found      <= 1'b0;
                        rot_amt    <= '0;
`ifdef ROT_DETECT_MASK_EN
                        match_mask <= '0;
`endif
                    end
                end
                SEARCH: begin
`ifdef ROT_DETECT_MASK_EN
                    match_mask <= mask_next;
                    if (cand == CAND_LAST) begin
                        found   <= |mask_next;
                        rot_amt <= lowest_set(mask_next);
                    end else begin
                        cand <= cand + AW'(1);
                    end
`else
                    if (hit) begin
                        found   <= 1'b1;
                        rot_amt <= cand;
                    end else if (cand == CAND_LAST) begin
                        found   <= 1'b0;
                        rot_amt <= '0;
                    end else begin
                        cand <= cand + AW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_detect.sv
// Bench for rotate_detect: directed operand cases plus random ones against a bit-index rotation model.
module tb_rotate_detect;

    localparam int N  = 16;
    localparam int AW = 4;
    localparam int WINDOW = N + 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  data_ref;
    logic [N-1:0]  data_rot;
    logic          rotate_operation;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] rot_amt;
`ifdef ROT_DETECT_MASK_EN
    logic [N-1:0]  match_mask;
`endif

    int checks = 0;
    int errors = 0;

    rotate_detect #(.N(N), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .data_ref        (data_ref),
        .data_rot        (data_rot),
        .rotate_operation(rotate_operation),
        .busy            (busy),
        .done            (done),
        .found           (found),
        .rot_amt         (rot_amt)
`ifdef ROT_DETECT_MASK_EN
        ,
        .match_mask      (match_mask)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of x lands at position (i+k) mod N for a left rotation.
    function automatic logic [N-1:0] model_rot(input logic [N-1:0] x, input int k, input bit left);
        logic [N-1:0] o;
        o = '0;
        for (int i = 0; i < N; i++) begin
            if (left) o[(i + k) % N] = x[i];
            else      o[i] = x[(i + k) % N];
        end
        return o;
    endfunction

    // poke: 0 none, 1 start pulse at cycle T+pc, 2 reset at cycle T+pc
    task automatic run_op(input string name, input logic [N-1:0] r, input logic [N-1:0] w,
                          input bit left, input int poke, input int pc);
        bit            exp_found;
        int            exp_amt;
        int            exp_lat;
        logic [N-1:0]  exp_mask;
        int            done_cnt;
        int            done_cyc;
        int            busy_bad;
        logic          f_at_done;
        logic [AW-1:0] a_at_done;
        bit            idle_ok;

        exp_found = 0;
        exp_amt   = 0;
        exp_mask  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (model_rot(r, k, left) == w) begin
                exp_found   = 1;
                exp_amt     = k;
                exp_mask[k] = 1'b1;
            end
        end
`ifdef ROT_DETECT_MASK_EN
        exp_lat = N + 1;
`else
        exp_lat = exp_found ? exp_amt + 2 : N + 1;
`endif

        idle_ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_ok = 1;
                break;
            end
        end
        chk({name, ".idle_wait"}, 32'(idle_ok), 32'd1);

        @(posedge clk);
        #1;
        data_ref = r;
        data_rot = w;
        rotate_operation = left;
        start = 1'b1;
        @(posedge clk);

        done_cnt = 0;
        done_cyc = 0;
        busy_bad = 0;
        f_at_done = 1'b0;
        a_at_done = '0;
        for (int c = 1; c <= WINDOW; c++) begin
            #1;
            start = (poke == 1 && c == pc);
            rst   = (poke == 2 && c == pc);
            if (poke == 1 && c == pc) begin
                data_ref = 16'($urandom);
                data_rot = 16'($urandom);
                rotate_operation = ~left;
            end
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin
                    done_cyc  = c;
                    f_at_done = found;
                    a_at_done = rot_amt;
                end
            end
            if (poke == 2) begin
                if (busy !== (c <= pc)) busy_bad++;
            end else begin
                if (busy !== (c <= exp_lat)) busy_bad++;
            end
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        rst   = 1'b0;

        chk({name, ".busy"}, 32'(busy_bad), 32'd0);
        if (poke == 2) begin
            chk({name, ".done_count"}, 32'(done_cnt), 32'd0);
            chk({name, ".found"}, 32'(found), 32'd0);
            chk({name, ".rot_amt"}, 32'(rot_amt), 32'd0);
`ifdef ROT_DETECT_MASK_EN
            chk({name, ".mask"}, 32'(match_mask), 32'd0);
`endif
        end else begin
            chk({name, ".done_count"}, 32'(done_cnt), 32'd1);
            chk({name, ".latency"}, 32'(done_cyc), 32'(exp_lat));
            chk({name, ".found"}, 32'(f_at_done), 32'(exp_found));
            chk({name, ".rot_amt"}, 32'(a_at_done), 32'(exp_amt));
            chk({name, ".found_hold"}, 32'(found), 32'(exp_found));
            chk({name, ".amt_hold"}, 32'(rot_amt), 32'(exp_amt));
`ifdef ROT_DETECT_MASK_EN
            chk({name, ".mask"}, 32'(match_mask), 32'(exp_mask));
`endif
        end
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] w;
        bit           left;

        rst = 1'b1;
        start = 1'b0;
        data_ref = '0;
        data_rot = '0;
        rotate_operation = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.found", 32'(found), 32'd0);
        chk("reset.rot_amt", 32'(rot_amt), 32'd0);
`ifdef ROT_DETECT_MASK_EN
        chk("reset.mask", 32'(match_mask), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op("left3",     16'h0001, 16'h0008, 1'b1, 0, 0);
        run_op("right13",   16'h0001, 16'h0008, 1'b0, 0, 0);
        run_op("identity",  16'h1234, 16'h1234, 1'b1, 0, 0);
        run_op("nomatch",   16'h0001, 16'h0003, 1'b1, 0, 0);
        run_op("periodic",  16'hAAAA, 16'h5555, 1'b1, 0, 0);
        run_op("zeros",     16'h0000, 16'h0000, 1'b0, 0, 0);
        run_op("ones",      16'hFFFF, 16'hFFFF, 1'b1, 0, 0);
        run_op("last_amt",  16'h0001, 16'h8000, 1'b1, 0, 0);
        run_op("busystart", 16'h0001, 16'h0008, 1'b1, 1, 3);
        run_op("abort",     16'h0001, 16'h0003, 1'b1, 2, 4);
        run_op("after_rst", 16'h00F0, 16'h0F00, 1'b1, 0, 0);

        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom);
            left = 1'($urandom);
            if (i % 2 == 0)
                w = model_rot(r, int'($urandom_range(0, N - 1)), ($urandom_range(0, 1) == 1));
            else
                w = 16'($urandom);
            run_op("random", r, w, left, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotate_detect.md
# rotate_detect

Sequential inverse of the ALU's `rotate_operation` unit. Given an original word and a rotated word, it searches rotation amounts one per cycle. It reports the smallest amount that maps the original onto the rotated word, in the requested direction. It sits beside the rotate unit in the UART ALU datapath and serves the "recover rotation" opcode and the self-check path. Handshake is start/busy/done.

## Interface
- `N`, 16, data width; power of two, ≥ 2
- `AW`, `$clog2(N)` (4), width of the amount field
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; accepted only when `busy`=0
- `data_ref`  in  N  original word; sampled on accept
- `data_rot`  in  N  rotated word; sampled on accept
- `rotate_operation`  in  1  1: search left rotations, 0: search right; sampled on accept
- `busy`  out  1  high from the cycle after accept through the DONE cycle
- `done`  out  1  one-cycle pulse; result valid
- `found`  out  1  1 if any amount matched
- `rot_amt`  out  AW  smallest matching amount (0 if none)
- `match_mask`  out  N  bit k set if amount k matches; present only with `ROT_DETECT_MASK_EN`

## Operation
- States: IDLE, SEARCH, DONE.
- **IDLE, `start`=1:** register the operands and the direction, clear `cand` to 0, go to SEARCH. Otherwise stay in IDLE.
- **SEARCH:** compare `rotate(ref_q, cand, dir_q)` against `rot_q`.
  - On a match, register `found`=1 and `rot_amt`=`cand`, then go to DONE (early exit).
  - On a miss with `cand`=N-1, register `found`=0 and `rot_amt`=0, then go to DONE.
  - On any other miss, increment `cand`.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- Rotation semantics are identical to `rotate_operation`:
  - left by k: `(x<<k)|(x>>(N-k))`
  - right by k: `(x>>k)|(x<<(N-k))`
  - k=0 is the identity.
- Direction relation: a left amount k equals a right amount (N-k) mod N. The test plan checks both.
- Ambiguous inputs (periodic words such as 0x0000, 0xFFFF, 0xAAAA) report the smallest k.
- `start` while `busy`=1 is ignored; there is no queueing.
- `found` and `rot_amt` hold their values from DONE until the next accept. They are cleared on accept.
- `cand` is AW bits and never wraps; termination happens at N-1.

## Timing
- Reset values:
  - state = IDLE
  - `busy`, `done`, `found`, `rot_amt`, `match_mask` = 0
- Let the accept cycle be T, with `start`=1 sampled at the edge ending T.
- `busy`=1 from T+1 until the DONE cycle, inclusive.
- Match at amount k: `done` is high in cycle T+2+k.
- No match: `done` is high in cycle T+N+1 (T+17 for N=16).
- The earliest next accept is the cycle after DONE, i.e. back-to-back with a 1-cycle IDLE gap.
- `rst` in any state returns to IDLE at the next edge.
  - No `done` pulse is produced for the aborted search.
  - All outputs are zeroed.
- `rst` has priority over `start` in the same cycle.

## Configuration
- `ROT_DETECT_MASK_EN` defined:
  - No early exit; all N amounts are always scanned.
  - `match_mask` accumulates one bit per candidate.
  - `rot_amt` is the lowest set bit, and `found` is the OR of the mask.
  - Latency is fixed: `done` is high at T+N+1.
  - The mask is cleared on accept and on reset.
- `ROT_DETECT_MASK_EN` undefined: the `match_mask` port and register are absent, and early-exit timing applies.

## Structure
- Package `rot_detect_pkg` holds:
  - the state enum typedef (IDLE/SEARCH/DONE)
  - default `N` = 16 and the derived `AW`
  - direction constants `ROT_LEFT`=1'b1 and `ROT_RIGHT`=1'b0
- Sub-module: instantiate the existing combinational `rotate_operation` for the candidate rotation. Its inputs are `ref_q`, `cand`, and `dir_q`; its output drives the comparator. Do not duplicate the rotate logic.

## Test plan
- `data_ref`=0x0001, `data_rot`=0x0008, dir=1 -> `found`=1, `rot_amt`=3, `done` at T+5.
- Same operands, dir=0 -> `found`=1, `rot_amt`=13, `done` at T+15.
- `data_ref`=0x1234, `data_rot`=0x1234, dir=1 -> `rot_amt`=0, `done` at T+2.
- `data_ref`=0x0001, `data_rot`=0x0003 -> `found`=0, `rot_amt`=0, `done` at T+17.
- `data_ref`=0xAAAA, `data_rot`=0x5555, dir=1:
  - without the macro -> `rot_amt`=1, `done` at T+3
  - with `ROT_DETECT_MASK_EN` -> `match_mask`=0xAAAA, `rot_amt`=1, `done` at T+17
- `start` pulsed at T+3 during a search -> ignored, the result is unchanged. `rst` at T+4 of a miss search -> `busy`=0 next cycle, no `done`. A new start then completes normally.
